// File: rtl/m_enemy_spawn_ctrl.sv
// Spawn sequencer for a pool of medium-enemy plane units: shared update tick, slot allocation,
// create pulse and live confirmation. Optional macro M_ENEMY_RR_EN selects round-robin allocation.
module m_enemy_spawn_ctrl #(
    parameter int NUM_SLOTS       = 4,
    parameter int TICK_DIV        = 833333,
    parameter int CREATE_HOLD     = 4,
    parameter int CONFIRM_TIMEOUT = 16,
    localparam int SW             = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 pause,
    input  logic                 spawn_req,
    input  logic [7:0]           spawn_x,
    input  logic [7:0]           spawn_y,
    output logic                 spawn_ready,
    output logic                 spawn_done,
    output logic                 spawn_drop,
    output logic                 spawn_err,
    output logic [SW-1:0]        spawn_slot,
    input  logic [NUM_SLOTS-1:0] slot_live,
    output logic [NUM_SLOTS-1:0] slot_create,
    output logic [7:0]           init_x,
    output logic [7:0]           init_y,
    output logic                 update_clk,
    output logic [SW:0]          live_count
);

    localparam int CW   = $clog2(TICK_DIV);
    localparam int TMAX = (CREATE_HOLD > CONFIRM_TIMEOUT) ? CREATE_HOLD : CONFIRM_TIMEOUT;
    localparam int TW   = $clog2(TMAX);
    localparam int LW   = SW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_CONFIRM = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [TW-1:0]         timer_r;
    logic [TW-1:0]         timer_s;
    logic [CW-1:0]         tick_cnt_r;
    logic                  update_clk_r;
    logic [LW-1:0]         live_count_r;
    logic [SW-1:0]         slot_r;
    logic [SW-1:0]         sel_slot_s;
    logic [SW-1:0]         target_s;
    logic [SW-1:0]         base_s;
    logic [NUM_SLOTS-1:0]  free_s;
    logic [NUM_SLOTS-1:0]  create_r;
    logic [7:0]            init_x_r;
    logic [7:0]            init_y_r;
    logic                  ready_r;
    logic                  done_r;
    logic                  drop_r;
    logic                  err_r;
    logic                  accept_s;
    logic                  alloc_s;
    logic                  done_s;
    logic                  drop_s;
    logic                  err_s;

    // First free slot at or after base, wrapping around the pool
    function automatic logic [SW-1:0] f_pick_slot(input logic [NUM_SLOTS-1:0] free,
                                                  input logic [SW-1:0] base);
        logic [SW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx = (int'(base) + i) % NUM_SLOTS;
            if (!found && free[SW'(idx)]) begin
                pick  = SW'(idx);
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [LW-1:0] f_popcount(input logic [NUM_SLOTS-1:0] v);
        logic [LW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt = cnt + LW'(v[i]);
        end
        return cnt;
    endfunction

    function automatic logic [NUM_SLOTS-1:0] f_onehot(input logic [SW-1:0] idx);
        return NUM_SLOTS'(1) << idx;
    endfunction

    assign free_s     = ~slot_live;
    assign sel_slot_s = f_pick_slot(free_s, base_s);
    assign target_s   = alloc_s ? sel_slot_s : slot_r;

`ifdef M_ENEMY_RR_EN
    logic [SW-1:0] rr_r;

    // Round-robin pointer advances past a slot only once it is confirmed live
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_r <= '0;
        end else if (done_s) begin
            rr_r <= (slot_r == SW'(NUM_SLOTS - 1)) ? '0 : slot_r + SW'(1);
        end else begin
            rr_r <= rr_r;
        end
    end

    assign base_s = rr_r;
`else
    assign base_s = '0;
`endif

    // Free-running update tick, frozen by pause
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_cnt_r   <= '0;
            update_clk_r <= 1'b0;
        end else if (pause) begin
            tick_cnt_r   <= tick_cnt_r;
            update_clk_r <= 1'b0;
        end else begin
            tick_cnt_r   <= (tick_cnt_r == CW'(TICK_DIV - 1)) ? '0 : tick_cnt_r + CW'(1);
            update_clk_r <= (tick_cnt_r < CW'(2));
        end
    end

    // Registered live-slot count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live_count_r <= '0;
        end else begin
            live_count_r <= f_popcount(slot_live);
        end
    end

    // Spawn FSM next-state and pulse decode
    always_comb begin
        state_s  = state_r;
        timer_s  = timer_r;
        accept_s = 1'b0;
        alloc_s  = 1'b0;
        done_s   = 1'b0;
        drop_s   = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (spawn_req && ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_SCAN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SCAN: begin
                timer_s = '0;
                if (free_s == '0) begin
                    drop_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    alloc_s = 1'b1;
                    state_s = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (timer_r == TW'(CREATE_HOLD - 1)) begin
                    timer_s = '0;
                    state_s = ST_CONFIRM;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            ST_CONFIRM: begin
                if (slot_live[slot_r]) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else if (timer_r == TW'(CONFIRM_TIMEOUT - 1)) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = '0;
            end
        endcase
    end

    // Spawn FSM state and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            timer_r  <= '0;
            slot_r   <= '0;
            create_r <= '0;
            init_x_r <= 8'd0;
            init_y_r <= 8'd0;
            ready_r  <= 1'b0;
            done_r   <= 1'b0;
            drop_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            timer_r  <= timer_s;
            slot_r   <= target_s;
            create_r <= (state_s == ST_ASSERT) ? f_onehot(target_s) : '0;
            init_x_r <= accept_s ? spawn_x : init_x_r;
            init_y_r <= accept_s ? spawn_y : init_y_r;
            ready_r  <= (state_s == ST_IDLE);
            done_r   <= done_s;
            drop_r   <= drop_s;
            err_r    <= err_s;
        end
    end

    assign spawn_ready = ready_r;
    assign spawn_done  = done_r;
    assign spawn_drop  = drop_r;
    assign spawn_err   = err_r;
    assign spawn_slot  = slot_r;
    assign slot_create = create_r;
    assign init_x      = init_x_r;
    assign init_y      = init_y_r;
    assign update_clk  = update_clk_r;
    assign live_count  = live_count_r;

endmodule

// File: tb/tb_m_enemy_spawn_ctrl.sv
// Randomized self-checking bench for m_enemy_spawn_ctrl against a transaction-level timeline model.
module tb_m_enemy_spawn_ctrl;

    localparam int NS = 4;
    localparam int TD = 20;
    localparam int CH = 4;
    localparam int CT = 16;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          pause = 1'b0;
    logic          spawn_req = 1'b0;
    logic [7:0]    spawn_x = 8'd0;
    logic [7:0]    spawn_y = 8'd0;
    logic          spawn_ready;
    logic          spawn_done;
    logic          spawn_drop;
    logic          spawn_err;
    logic [SW-1:0] spawn_slot;
    logic [NS-1:0] slot_live = '0;
    logic [NS-1:0] slot_create;
    logic [7:0]    init_x;
    logic [7:0]    init_y;
    logic          update_clk;
    logic [SW:0]   live_count;

    int            n_cmp = 0;
    int            n_err = 0;
    int            active_edges = 0;
    bit            in_rst = 1'b1;
    logic [NS-1:0] live_q = '0;
    int            rr_m = 0;
    int            last_slot = 0;
    logic [7:0]    exp_x = 8'd0;
    logic [7:0]    exp_y = 8'd0;

    always #5 clk = ~clk;

    m_enemy_spawn_ctrl #(
        .NUM_SLOTS(NS), .TICK_DIV(TD), .CREATE_HOLD(CH), .CONFIRM_TIMEOUT(CT)
    ) dut (
        .clk(clk), .rstn(rstn), .pause(pause),
        .spawn_req(spawn_req), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .spawn_ready(spawn_ready), .spawn_done(spawn_done), .spawn_drop(spawn_drop),
        .spawn_err(spawn_err), .spawn_slot(spawn_slot),
        .slot_live(slot_live), .slot_create(slot_create),
        .init_x(init_x), .init_y(init_y),
        .update_clk(update_clk), .live_count(live_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int pick(input logic [NS-1:0] live, input int base);
        logic [NS-1:0] v;
        int j;
        for (int i = 0; i < NS; i++) begin
            j = (base + i) % NS;
            v = live >> j;
            if (!v[0]) return j;
        end
        return -1;
    endfunction

    function automatic logic [NS-1:0] onehot(input int s);
        logic [NS-1:0] one;
        one = 1;
        return one << s;
    endfunction

    // One clock: outputs sampled 1 time unit after the edge; tick and live count checked every cycle
    task automatic step();
        logic          p;
        logic          eu;
        logic [NS-1:0] lv;
        p  = pause;
        lv = slot_live;
        @(posedge clk);
        #1;
        if (!in_rst) begin
            if (p) begin
                eu = 1'b0;
            end else begin
                eu = ((active_edges % TD) < 2);
                active_edges++;
            end
            chk("update_clk", update_clk, eu);
            chk("live_count", live_count, $countones(lv));
        end
    endtask

    // Sample k counts clocks after the request was driven: SCAN at 1, create 2..CH+1, confirm window after
    task automatic do_spawn(input logic [7:0] x, input logic [7:0] y, input int d, input bit bogus);
        int s, k, ncre, first_k, live_k, done_k, err_k, drop_k, n_done, n_errp, n_drop, exp_k, cf;
        s = pick(live_q, rr_m);
        k = 0;
        while (spawn_ready !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        chk("ready_before_req", spawn_ready, 1);
        spawn_x = x; spawn_y = y; spawn_req = 1'b1;
        step();
        spawn_req = 1'b0; spawn_x = 8'($urandom); spawn_y = 8'($urandom);
        exp_x = x; exp_y = y;
        chk("ready_after_accept", spawn_ready, 0);
        ncre = 0; first_k = -1; done_k = -1; err_k = -1; drop_k = -1;
        n_done = 0; n_errp = 0; n_drop = 0;
        live_k = (d < 0) ? 1000 : 2 + d;
        cf = 2 + CH;
        for (k = 2; k <= 30; k++) begin
            if (bogus && s >= 0 && k == 4) begin
                spawn_req = 1'b1; spawn_x = ~x; spawn_y = ~y;
            end else begin
                spawn_req = 1'b0;
            end
            step();
            chk("init_x", init_x, exp_x);
            chk("init_y", init_y, exp_y);
            if (slot_create != '0) begin
                if (first_k < 0) first_k = k;
                ncre++;
                chk("create_onehot", slot_create, onehot(s));
            end
            if (spawn_done) begin n_done++; if (done_k < 0) done_k = k; end
            if (spawn_err)  begin n_errp++; if (err_k < 0) err_k = k; end
            if (spawn_drop) begin n_drop++; if (drop_k < 0) drop_k = k; end
            if (k == live_k && s >= 0) begin
                live_q = live_q | onehot(s);
                slot_live = live_q;
            end
        end
        spawn_req = 1'b0;
        if (s < 0) begin
            chk("drop_k", drop_k, 2);
            chk("drop_pulses", n_drop, 1);
            chk("create_cnt", ncre, 0);
            chk("done_err_pulses", n_done + n_errp, 0);
            chk("slot_held", spawn_slot, last_slot);
        end else begin
            chk("create_first", first_k, 2);
            chk("create_cnt", ncre, CH);
            chk("drop_pulses", n_drop, 0);
            if (live_k <= cf + CT - 1) begin
                exp_k = ((live_k < cf) ? cf : live_k) + 1;
                chk("done_k", done_k, exp_k);
                chk("done_pulses", n_done, 1);
                chk("err_pulses", n_errp, 0);
`ifdef M_ENEMY_RR_EN
                rr_m = (s + 1) % NS;
`endif
            end else begin
                chk("err_k", err_k, cf + CT);
                chk("err_pulses", n_errp, 1);
                chk("done_pulses", n_done, 0);
            end
            chk("spawn_slot", spawn_slot, s);
            last_slot = s;
        end
        chk("ready_after_spawn", spawn_ready, 1);
    endtask

    task automatic set_live(input logic [NS-1:0] v);
        live_q = v;
        slot_live = v;
    endtask

    initial begin
        step();
        step();
        chk("reset_outputs", {spawn_ready, spawn_done, spawn_drop, spawn_err, spawn_slot,
                              slot_create, init_x, init_y, update_clk, live_count}, 0);
        rstn = 1'b1; in_rst = 1'b0; active_edges = 0;
        step();
        chk("ready_after_reset", spawn_ready, 1);
        for (int i = 0; i < 44; i++) step();

        // Pause mid-count, then resume
        pause = 1'b1;
        for (int i = 0; i < 50; i++) step();
        pause = 1'b0;
        for (int i = 0; i < 30; i++) step();

        set_live(4'b0000);
        do_spawn(8'd40, 8'd12, 3, 1'b0);
        chk("first_slot", spawn_slot, 0);
        set_live(4'b1011);
        do_spawn(8'd7, 8'd99, 3, 1'b1);
        chk("slot_when_1011", spawn_slot, 2);
        set_live(4'b1111);
        do_spawn(8'd1, 8'd2, 3, 1'b0);
        set_live(4'b0000);
        do_spawn(8'd55, 8'd66, -1, 1'b0);

        // Reset while create is asserted
        set_live(4'b0000);
        while (spawn_ready !== 1'b1) step();
        spawn_x = 8'd9; spawn_y = 8'd8; spawn_req = 1'b1;
        step();
        spawn_req = 1'b0;
        step();
        step();
        chk("create_before_rst", slot_create, 4'b0001);
        rstn = 1'b0; in_rst = 1'b1;
        #1;
        chk("rst_create", slot_create, 0);
        chk("rst_pulses", {spawn_done, spawn_err, spawn_drop, spawn_ready}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_pulse", {spawn_done, spawn_err}, 0);
        end
        rstn = 1'b1; in_rst = 1'b0; active_edges = 0;
        rr_m = 0; last_slot = 0; exp_x = 8'd0; exp_y = 8'd0;
        step();
        chk("ready_after_rst", spawn_ready, 1);

        for (int i = 0; i < 3; i++) begin
            do_spawn(8'($urandom), 8'($urandom), 3, 1'b0);
            chk("seq_slot", spawn_slot, i);
        end

        for (int n = 0; n < 40; n++) begin
            pause = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: set_live(4'b1111);
                1: set_live(4'($urandom));
                default: set_live(live_q & 4'($urandom));
            endcase
            do_spawn(8'($urandom), 8'($urandom),
                     ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 8)),
                     1'($urandom_range(0, 1)));
        end
        pause = 1'b0;
        for (int i = 0; i < 25; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
